neighbour_window: RTL

- Streaming window generator that sits directly upstream of the 8-input neighbour summer in the Game of Life datapath.
- Accepts one board of cell bits in raster order (row 0 col 0 first) and emits, for every cell in the same raster order, the cell's own state plus its 8 neighbour bits. The summer consumes those 8 bits.
- Cells outside the board read as dead (zero padding).
- Buffers two rows plus three cells internally, with valid/ready on both sides.

---
 rtl/neighbour_window.sv | 120 ++++++++++++
 1 files changed

// File: rtl/neighbour_window.sv
// Raster-order cell stream to 3x3 neighbour window; define NEIGHBOUR_WINDOW_LIVE_BORDER_EN for a live (1) border.
// Registered output one edge after the loading step; input stalls while a window is held unconsumed.
module neighbour_window #(
  parameter int COLS = 8,
  parameter int ROWS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_cell,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_center,
  output logic [7:0] out_neighbors,
  output logic       out_last
);
  localparam int SRW = 2*COLS+3;
  localparam int KW  = $clog2(ROWS*COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]     state;
  logic [KW-1:0]  k;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [SRW-1:0] sr;
  logic [SRW-1:0] sr_next;
  logic           shift_bit;
  logic           free;
  logic           fill_acc;
  logic           step;
  logic           top, bot, left, right;
  logic [7:0]     raw;
  logic [7:0]     edge_mask;
  logic [7:0]     nb;

  assign free      = !out_valid || out_ready;
  assign fill_acc  = (state == FILL) && in_valid;
  assign step      = ((state == RUN) && in_valid && free) || ((state == DRAIN) && free);
  assign shift_bit = (state == DRAIN) ? 1'b0 : in_cell;
  assign sr_next   = {sr[SRW-2:0], shift_bit};

  always_comb begin
    in_ready = 1'b0;
    case (state)
      FILL:    in_ready = 1'b1;
      RUN:     in_ready = free;
      default: in_ready = 1'b0;
    endcase
  end

  // Row/col track the cell whose window is being loaded this step.
  assign top   = (row == '0);
  assign bot   = (row == RW'(ROWS-1));
  assign left  = (col == '0);
  assign right = (col == CW'(COLS-1));

  // Bit order SE,S,SW,E,W,NE,N,NW from bit 7 down to bit 0.
  assign raw = {sr_next[0], sr_next[1], sr_next[2], sr_next[COLS],
                sr_next[COLS+2], sr_next[2*COLS], sr_next[2*COLS+1], sr_next[2*COLS+2]};
  assign edge_mask = {bot | right, bot, bot | left, right, left, top | right, top, top | left};

`ifdef NEIGHBOUR_WINDOW_LIVE_BORDER_EN
  assign nb = raw | edge_mask;
`else
  assign nb = raw & ~edge_mask;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= FILL;
      k             <= '0;
      row           <= '0;
      col           <= '0;
      sr            <= '0;
      out_valid     <= 1'b0;
      out_center    <= 1'b0;
      out_neighbors <= '0;
      out_last      <= 1'b0;
    end else begin
      if (fill_acc || step) sr <= sr_next;

      case (state)
        FILL: if (fill_acc) begin
          k <= k + KW'(1);
          if (k == KW'(COLS)) state <= RUN;
        end
        RUN: if (step) begin
          k <= k + KW'(1);
          if (k == KW'(ROWS*COLS-1)) state <= DRAIN;
        end
        DRAIN: if (step && bot && right) begin
          state <= FILL;
          k     <= '0;
        end
        default: state <= FILL;
      endcase

      if (step) begin
        out_valid     <= 1'b1;
        out_center    <= sr_next[COLS+1];
        out_neighbors <= nb;
        out_last      <= bot && right;
        if (right) begin
          col <= '0;
          row <= bot ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
